// File: rtl/blueberry_pkg.sv
// blueberry_pkg: shared instruction encodings, sequencer state type and decode helpers
package blueberry_pkg;
  localparam int INSTR_W = 10;
  localparam logic [1:0] TYPE_MOV = 2'b00;
  localparam logic [1:0] TYPE_ALU = 2'b01;
  localparam logic [1:0] TYPE_IMM = 2'b10;
  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_COPY = 4'b0001;
  localparam logic [INSTR_W-1:0] HALT_WORD = 10'h03C;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALTED, FAULT} seq_state_t;
  function automatic logic is_load(input logic [INSTR_W-1:0] word);
    return word[1:0] == TYPE_MOV && word[5:2] == OP_LOAD;
  endfunction
endpackage

// File: rtl/program_sequencer_if.sv
// program_sequencer_if: program load, control and data-bus signals of the sequencer
interface program_sequencer_if #(parameter int ADDR_W = 6);
  import blueberry_pkg::*;
  logic prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [INSTR_W-1:0] prog_wdata;
  logic start;
  logic Clr;
  logic [INSTR_W-1:0] data;
  logic [1:0] timestep;
  logic [ADDR_W-1:0] pc;
  logic busy;
  logic done;
  logic overflow;
  modport master (
    output prog_we, prog_addr, prog_wdata, start, Clr,
    input data, timestep, pc, busy, done, overflow
  );
  modport slave (
    input prog_we, prog_addr, prog_wdata, start, Clr,
    output data, timestep, pc, busy, done, overflow
  );
endinterface

// File: rtl/program_ram.sv
// program_ram: DEPTH x INSTR_W program store, synchronous write, combinational read
module program_ram
  import blueberry_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: issues program words onto the data bus and owns the timestep counter
module program_sequencer
  import blueberry_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  program_sequencer_if.slave bus
);
  seq_state_t state, nstate;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [1:0] ts, ts_n;
  logic [INSTR_W-1:0] cur_instr, rdata;
  logic running, go, load_op, adv, wrap;
  assign running = state == FETCH || state == EXEC;
  assign go = bus.start && !running;
  assign load_op = state == EXEC && ts == 2'd1 && is_load(cur_instr);
  assign adv = (state == FETCH && rdata != HALT_WORD) || load_op;
  assign wrap = adv && pc == ADDR_W'(DEPTH - 1);
  program_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(bus.prog_we && !running),
    .waddr(bus.prog_addr),
    .wdata(bus.prog_wdata),
    .raddr(pc),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      ts <= 2'd0;
    end else begin
      state <= nstate;
      pc <= pc_n;
      ts <= ts_n;
    end
  end
  always_ff @(posedge clk)
    if (state == FETCH) cur_instr <= rdata;
  // Overflow takes priority over Clr so a wrapping LOAD operand still faults.
  always_comb begin
    nstate = state;
    pc_n = pc;
    ts_n = ts;
    if (go) begin
      nstate = FETCH;
      pc_n = '0;
      ts_n = 2'd0;
    end else if (wrap) begin
      nstate = FAULT;
      pc_n = '0;
      ts_n = 2'd0;
    end else if (state == FETCH) begin
      nstate = adv ? EXEC : HALTED;
      pc_n = adv ? pc + 1'b1 : pc;
      ts_n = adv ? 2'd1 : 2'd0;
    end else if (state == EXEC) begin
      nstate = (bus.Clr || ts == 2'd3) ? FETCH : EXEC;
      pc_n = load_op ? pc + 1'b1 : pc;
      ts_n = bus.Clr ? 2'd0 : ts + 2'd1;
    end
  end
  always_comb begin
    bus.data = (state == FETCH || load_op) ? rdata : '0;
    bus.timestep = ts;
    bus.pc = pc;
    bus.busy = running;
    bus.done = state == HALTED;
    bus.overflow = state == FAULT;
  end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed scenario checks of the program sequencer
module tb_program_sequencer;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  program_sequencer_if #(.ADDR_W(6)) bus ();
  program_sequencer_if #(.ADDR_W(2)) sb ();
  program_sequencer #(.DEPTH(64), .ADDR_W(6)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  program_sequencer #(.DEPTH(4), .ADDR_W(2)) dut4 (.clk(clk), .reset(reset), .bus(sb.slave));
  int total = 0;
  int passed = 0;
  logic [20:0] exp;
  logic [16:0] exp4;
  function automatic logic [20:0] snap();
    return {bus.data, bus.timestep, bus.pc, bus.busy, bus.done, bus.overflow};
  endfunction
  function automatic logic [20:0] st(input logic [9:0] d, input logic [1:0] t, input logic [5:0] p,
                                     input logic b, input logic dn, input logic o);
    return {d, t, p, b, dn, o};
  endfunction
  function automatic logic [16:0] snap4();
    return {sb.data, sb.timestep, sb.pc, sb.busy, sb.done, sb.overflow};
  endfunction
  function automatic logic [16:0] st4(input logic [9:0] d, input logic [1:0] t, input logic [1:0] p,
                                      input logic b, input logic dn, input logic o);
    return {d, t, p, b, dn, o};
  endfunction
  task automatic nxt();
    @(negedge clk);
  endtask
  task automatic wr(input logic [5:0] a, input logic [9:0] w);
    bus.prog_we = 1; bus.prog_addr = a; bus.prog_wdata = w;
    nxt();
    bus.prog_we = 0;
  endtask
  task automatic go();
    bus.start = 1;
    nxt();
    bus.start = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    nxt(); nxt();
    exp = st(10'h0, 2'd0, 6'd0, 0, 0, 0);
    if (snap() !== exp) $display("FAIL reset got %h want %h", snap(), exp); else passed++;
    total++;
    exp4 = st4(10'h0, 2'd0, 2'd0, 0, 0, 0);
    if (snap4() !== exp4) $display("FAIL reset4 got %h want %h", snap4(), exp4); else passed++;
    total++;
    reset = 0;
  endtask
  task automatic test_load();
    wr(0, 10'h100); wr(1, 10'h02A); wr(2, 10'h03C);
    go();
    exp = st(10'h100, 2'd0, 6'd0, 1, 0, 0);
    if (snap() !== exp) $display("FAIL load_fetch got %h want %h", snap(), exp); else passed++;
    total++;
    nxt();
    exp = st(10'h02A, 2'd1, 6'd1, 1, 0, 0);
    if (snap() !== exp) $display("FAIL load_operand got %h want %h", snap(), exp); else passed++;
    total++;
    bus.Clr = 1; nxt(); bus.Clr = 0;
    exp = st(10'h03C, 2'd0, 6'd2, 1, 0, 0);
    if (snap() !== exp) $display("FAIL load_halt_fetch got %h want %h", snap(), exp); else passed++;
    total++;
    nxt();
    exp = st(10'h0, 2'd0, 6'd2, 0, 1, 0);
    if (snap() !== exp) $display("FAIL load_halted got %h want %h", snap(), exp); else passed++;
    total++;
  endtask
  task automatic test_copy_add();
    logic [9:0] d [7] = '{10'h244, 10'h0, 10'h048, 10'h0, 10'h0, 10'h0, 10'h03C};
    logic [1:0] t [7] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [5:0] p [7] = '{6'd0, 6'd1, 6'd1, 6'd2, 6'd2, 6'd2, 6'd2};
    wr(0, 10'h244); wr(1, 10'h048); wr(2, 10'h03C);
    go();
    for (int i = 0; i < 7; i++) begin
      exp = st(d[i], t[i], p[i], 1, 0, 0);
      if (snap() !== exp) $display("FAIL copy_add step %0d got %h want %h", i, snap(), exp); else passed++;
      total++;
      bus.Clr = (i == 1 || i == 5);
      nxt();
      bus.Clr = 0;
    end
    exp = st(10'h0, 2'd0, 6'd2, 0, 1, 0);
    if (snap() !== exp) $display("FAIL copy_add_done got %h want %h", snap(), exp); else passed++;
    total++;
  endtask
  task automatic test_watchdog();
    logic [9:0] d [5] = '{10'h048, 10'h0, 10'h0, 10'h0, 10'h03C};
    logic [1:0] t [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [5:0] p [5] = '{6'd0, 6'd1, 6'd1, 6'd1, 6'd1};
    wr(0, 10'h048); wr(1, 10'h03C);
    go();
    for (int i = 0; i < 5; i++) begin
      exp = st(d[i], t[i], p[i], 1, 0, 0);
      if (snap() !== exp) $display("FAIL watchdog step %0d got %h want %h", i, snap(), exp); else passed++;
      total++;
      nxt();
    end
    exp = st(10'h0, 2'd0, 6'd1, 0, 1, 0);
    if (snap() !== exp) $display("FAIL watchdog_done got %h want %h", snap(), exp); else passed++;
    total++;
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      sb.prog_we = 1; sb.prog_addr = 2'(i); sb.prog_wdata = 10'h244;
      nxt();
    end
    sb.prog_we = 0;
    sb.start = 1; nxt(); sb.start = 0;
    for (int i = 0; i < 3; i++) begin
      exp4 = st4(10'h244, 2'd0, 2'(i), 1, 0, 0);
      if (snap4() !== exp4) $display("FAIL ovf_fetch %0d got %h want %h", i, snap4(), exp4); else passed++;
      total++;
      nxt();
      exp4 = st4(10'h0, 2'd1, 2'(i + 1), 1, 0, 0);
      if (snap4() !== exp4) $display("FAIL ovf_exec %0d got %h want %h", i, snap4(), exp4); else passed++;
      total++;
      sb.Clr = 1; nxt(); sb.Clr = 0;
    end
    exp4 = st4(10'h244, 2'd0, 2'd3, 1, 0, 0);
    if (snap4() !== exp4) $display("FAIL ovf_last_fetch got %h want %h", snap4(), exp4); else passed++;
    total++;
    nxt();
    exp4 = st4(10'h0, 2'd0, 2'd0, 0, 0, 1);
    if (snap4() !== exp4) $display("FAIL ovf_fault got %h want %h", snap4(), exp4); else passed++;
    total++;
    sb.start = 1; nxt(); sb.start = 0;
    exp4 = st4(10'h244, 2'd0, 2'd0, 1, 0, 0);
    if (snap4() !== exp4) $display("FAIL ovf_restart got %h want %h", snap4(), exp4); else passed++;
    total++;
  endtask
  task automatic test_guarded();
    wr(0, 10'h244); wr(1, 10'h03C);
    go();
    bus.prog_we = 1; bus.prog_addr = 6'd1; bus.prog_wdata = 10'h100; bus.start = 1;
    nxt();
    bus.prog_we = 0; bus.start = 0;
    exp = st(10'h0, 2'd1, 6'd1, 1, 0, 0);
    if (snap() !== exp) $display("FAIL guard_start got %h want %h", snap(), exp); else passed++;
    total++;
    nxt(); nxt(); nxt();
    exp = st(10'h03C, 2'd0, 6'd1, 1, 0, 0);
    if (snap() !== exp) $display("FAIL guard_mem got %h want %h", snap(), exp); else passed++;
    total++;
    nxt();
  endtask
  task automatic test_reset_mid();
    wr(0, 10'h100); wr(1, 10'h2AA); wr(2, 10'h03C);
    go();
    nxt();
    exp = st(10'h2AA, 2'd1, 6'd1, 1, 0, 0);
    if (snap() !== exp) $display("FAIL mid_operand got %h want %h", snap(), exp); else passed++;
    total++;
    reset = 1; nxt(); reset = 0;
    exp = st(10'h0, 2'd0, 6'd0, 0, 0, 0);
    if (snap() !== exp) $display("FAIL mid_reset got %h want %h", snap(), exp); else passed++;
    total++;
    go();
    exp = st(10'h100, 2'd0, 6'd0, 1, 0, 0);
    if (snap() !== exp) $display("FAIL mid_restart got %h want %h", snap(), exp); else passed++;
    total++;
  endtask
  task automatic test_back_to_back();
    reset = 1; nxt(); reset = 0;
    bus.prog_we = 1; bus.prog_addr = 6'd0; bus.prog_wdata = 10'h03C; bus.start = 1;
    nxt();
    bus.prog_we = 0; bus.start = 0;
    exp = st(10'h03C, 2'd0, 6'd0, 1, 0, 0);
    if (snap() !== exp) $display("FAIL we_start_fetch got %h want %h", snap(), exp); else passed++;
    total++;
    nxt();
    exp = st(10'h0, 2'd0, 6'd0, 0, 1, 0);
    if (snap() !== exp) $display("FAIL we_start_done got %h want %h", snap(), exp); else passed++;
    total++;
  endtask
  initial begin
    bus.prog_we = 0; bus.prog_addr = '0; bus.prog_wdata = '0; bus.start = 0; bus.Clr = 0;
    sb.prog_we = 0; sb.prog_addr = '0; sb.prog_wdata = '0; sb.start = 0; sb.Clr = 0;
    test_reset();
    test_load();
    test_copy_add();
    test_watchdog();
    test_overflow();
    test_guarded();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction-issue side of the processor's external data bus. Holds a small loadable program memory, owns the 2-bit timestep counter, and drives each instruction word onto `data` at timestep 00. For LOAD, it also drives the following operand word at timestep 01. It advances on the controller's `Clr` and stops on a HALT word or on program-counter overflow.

## Interface
- `DEPTH`, 64, program memory words (power of two)
- `ADDR_W`, 6, $clog2(DEPTH)
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `prog_we`  in  1  program write strobe
- `prog_addr`  in  ADDR_W  program write address
- `prog_wdata`  in  10  program write word
- `start`  in  1  begin execution at address 0
- `Clr`  in  1  timestep clear from the processor controller
- `data`  out  10  external data bus word to the processor
- `timestep`  out  2  timestep counter to the controller
- `pc`  out  ADDR_W  address of next word to issue
- `busy`  out  1  sequencer running
- `done`  out  1  HALT reached (sticky until `start` or `reset`)
- `overflow`  out  1  `pc` wrapped without HALT (sticky until `start` or `reset`)

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- Word format: [9:8] Rx, [7:6] Ry, [5:2] op, [1:0] type.
- LOAD = type 00, op 0000.
- HALT_WORD = 10'h03C (type 00, op 1111).
- States: IDLE, FETCH (timestep 00), EXEC (timestep 01..11), HALTED, FAULT.
- IDLE:
  - `data` = 0, `timestep` = 00.
  - `start` → FETCH, `pc` ← 0, clears `done` and `overflow`.
- FETCH:
  - `data` = mem[`pc`], latched into internal `cur_instr` at the clock edge.
  - If the word is HALT_WORD: → HALTED, `pc` is not incremented.
  - Otherwise: `pc` ← `pc`+1, `timestep` ← 01, → EXEC.
- EXEC:
  - If `cur_instr` is LOAD and `timestep` = 01: `data` = mem[`pc`] and `pc` ← `pc`+1.
  - Otherwise `data` = 0.
  - `Clr` high → `timestep` ← 00, → FETCH.
  - Otherwise `timestep` ← `timestep`+1.
  - If `timestep` = 11 without `Clr`, the counter wraps to 00 and the state returns to FETCH (watchdog).
- `Clr` is ignored in FETCH. The controller decodes a stale IR at timestep 00.
- Overflow: any `pc` increment from DEPTH-1 → `pc` ← 0, `overflow` ← 1, → FAULT.
- HALTED and FAULT:
  - `data` = 0, `timestep` = 00.
  - `start` restarts exactly as from IDLE.
- `busy` = 1 in FETCH and EXEC only.
- `done` = 1 in HALTED.
- Program writes: `prog_we` writes mem[`prog_addr`] only when `busy` = 0; ignored while busy. `start` is ignored while busy.

## Timing
- Reset values: state IDLE, `pc` = 0, `timestep` = 00, `data` = 0, `busy` = 0, `done` = 0, `overflow` = 0.
- Memory contents are not reset.
- `start` sampled at edge N → FETCH at N+1, with `data` = mem[0] during cycle N+1.
- Memory read is combinational; `data` is valid in the same cycle as `pc`/`timestep`.
- Per-instruction length in cycles:
  - LOAD and COPY: 2 (`Clr` at timestep 01).
  - ALU and immediate: 4.
- `reset` mid-instruction: all outputs return to reset values on the next edge. No partial `pc` increment survives.
- `prog_we` and `start` in the same idle cycle: the write completes, and FETCH in the next cycle reads the updated word if the address is 0.

## Structure
- Shared package `blueberry_pkg`:
  - `INSTR_W` = 10
  - type codes, `OP_LOAD`, `OP_COPY`, `HALT_WORD`
  - `seq_state_t` enum
  - helper function `is_load(word)`
- Sub-module `program_ram`: DEPTH x 10, synchronous write, combinational read, no reset.
- `program_sequencer` contains the FSM, `pc`, timestep counter and `cur_instr` register.

## Test plan
- LOAD R1 then HALT:
  - Stimulus: program {0x100, 0x02A, 0x03C}, `start`, `Clr` pulsed at timestep 01.
  - Response: `data` = 0x100, then 0x02A; `pc` = 2; HALTED with `done` = 1 after 3 cycles.
- COPY then ADD then HALT:
  - Stimulus: program {0x244, 0x048, 0x03C}; `Clr` at timestep 01 for COPY and timestep 11 for ADD.
  - Response: `timestep` sequence 00,01,00,01,10,11,00; `data` = 0 during EXEC.
- Watchdog:
  - Stimulus: program {0x048, 0x03C} with `Clr` held low.
  - Response: `timestep` wraps 11→00 and FETCH issues 0x03C; `done` = 1.
- Overflow:
  - Stimulus: DEPTH = 4, program {0x244 ×4} with no HALT.
  - Response: after the 4th fetch `pc` = 0, `overflow` = 1, `busy` = 0.
- Guarded inputs:
  - Stimulus: `prog_we` to address 1 and `start` while busy.
  - Response: memory unchanged and `pc` unperturbed.
- Reset mid-run:
  - Stimulus: `reset` during LOAD timestep 01.
  - Response: next cycle all outputs at reset values; a re-`start` issues mem[0] again.
